tof_frame_scheduler: RTL

Frame-level scheduler for the ToF sensing chain. On a frame trigger it round-robin arbitrates the data-ready requests of up to eight enabled sensors and grants the single shared capture engine to one sensor at a time. Once every enabled sensor has been captured or has failed, it starts the surface-build FSM (its `drdy`), waits for completion, and reports frame status to the AXI/CPU side.

---
 rtl/tof_frame_scheduler_if.sv | 29 ++
 rtl/tof_frame_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tof_frame_scheduler_if.sv
// Sensor, capture-engine, surface-build and status signals of the ToF frame scheduler.
// The scheduler side uses the master modport; the surrounding chain uses slave.
interface tof_frame_scheduler_if #(
    parameter int N_SENS = 8
);
    logic              trig;
    logic [N_SENS-1:0] sens_en;
    logic [N_SENS-1:0] sens_drdy;
    logic              cap_start;
    logic [2:0]        cap_sens;
    logic              cap_done;
    logic              cap_err;
    logic              surf_start;
    logic              surf_done;
    logic              busy;
    logic [N_SENS-1:0] captured;
    logic              frame_done;
    logic              frame_err;

    modport master (
        input  trig, sens_en, sens_drdy, cap_done, cap_err, surf_done,
        output cap_start, cap_sens, surf_start, busy, captured, frame_done, frame_err
    );

    modport slave (
        output trig, sens_en, sens_drdy, cap_done, cap_err, surf_done,
        input  cap_start, cap_sens, surf_start, busy, captured, frame_done, frame_err
    );
endinterface

// File: rtl/tof_frame_scheduler.sv
// Frame scheduler: round-robin grants of the shared capture engine, then surface build.
// Optional per-grant timeout is enabled by defining TOF_SCHED_TIMEOUT_EN.
module tof_frame_scheduler #(
    parameter int N_SENS      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic                   clk,
    input logic                   rst,
    tof_frame_scheduler_if.master bus
);
    // state   | meaning
    // IDLE    | waiting for trig
    // ARB     | picking next pending+ready sensor
    // CAPTURE | capture engine busy on cap_sens
    // BUILD   | surface build running (or skipped if nothing captured)
    // DONE    | one-cycle frame_done
    typedef enum logic [2:0] {IDLE, ARB, CAPTURE, BUILD, DONE} state_t;

    state_t            state_q, state_d;
    logic [N_SENS-1:0] pend_q, pend_d, captured_q, captured_d, req;
    logic [2:0]        rr_q, rr_d, cap_sens_q, cap_sens_d, win, idx;
    logic              req_any, tmr_tc;
    logic              frame_err_q, frame_err_d;
    logic              cap_start_q, cap_start_d;
    logic              surf_start_q, surf_start_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q;

`ifdef TOF_SCHED_TIMEOUT_EN
    logic [12:0] tmr_q;

    // Down-counter reloaded on every state change; terminal count is zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmr_q <= '0;
        else if (state_d != state_q)
            tmr_q <= 13'(TIMEOUT_CYC - 1);
        else if (tmr_q != '0)
            tmr_q <= tmr_q - 13'd1;
    end

    assign tmr_tc = (tmr_q == '0) && (state_q == ARB || state_q == CAPTURE);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign tmr_tc = 1'b0;
`endif

    // Scan from highest offset down so the closest request at/after rr wins.
    always_comb begin
        req     = pend_q & bus.sens_drdy;
        win     = '0;
        idx     = '0;
        req_any = 1'b0;
        for (int i = N_SENS - 1; i >= 0; i--) begin
            idx = 3'((int'(rr_q) + i) % N_SENS);
            if (req[idx]) begin
                win     = idx;
                req_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        captured_d   = captured_q;
        frame_err_d  = frame_err_q;
        rr_d         = rr_q;
        cap_sens_d   = cap_sens_q;
        cap_start_d  = 1'b0;
        surf_start_d = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.trig) begin
                    pend_d      = bus.sens_en;
                    captured_d  = '0;
                    frame_err_d = 1'b0;
                    if (bus.sens_en == '0) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ARB;
                    end
                end
            end
            ARB: begin
                if (req_any) begin
                    cap_sens_d  = win;
                    rr_d        = (win == 3'(N_SENS - 1)) ? 3'd0 : win + 3'd1;
                    cap_start_d = 1'b1;
                    state_d     = CAPTURE;
                end else if (tmr_tc) begin
                    frame_err_d  = 1'b1;
                    pend_d       = '0;
                    state_d      = BUILD;
                    surf_start_d = (captured_q != '0);
                end
            end
            CAPTURE: begin
                if (bus.cap_err || bus.cap_done || tmr_tc) begin
                    if (bus.cap_done && !bus.cap_err)
                        captured_d[cap_sens_q] = 1'b1;
                    else
                        frame_err_d = 1'b1;
                    pend_d[cap_sens_q] = 1'b0;
                    if (pend_d != '0) begin
                        state_d = ARB;
                    end else begin
                        state_d      = BUILD;
                        surf_start_d = (captured_d != '0);
                    end
                end
            end
            BUILD: begin
                if (captured_q == '0 || bus.surf_done) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            captured_q   <= '0;
            frame_err_q  <= 1'b0;
            rr_q         <= '0;
            cap_sens_q   <= '0;
            cap_start_q  <= 1'b0;
            surf_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            captured_q   <= captured_d;
            frame_err_q  <= frame_err_d;
            rr_q         <= rr_d;
            cap_sens_q   <= cap_sens_d;
            cap_start_q  <= cap_start_d;
            surf_start_q <= surf_start_d;
            frame_done_q <= frame_done_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign bus.cap_start  = cap_start_q;
    assign bus.cap_sens   = cap_sens_q;
    assign bus.surf_start = surf_start_q;
    assign bus.busy       = busy_q;
    assign bus.captured   = captured_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
endmodule
